// File: rtl/sort_result_serializer.sv
// Captures one sorted vector from the sorting network and streams it out one
// word per valid/ready transfer; vectors arriving while busy are dropped and flagged.
module sort_result_serializer #(
    parameter int LOG_INPUT_NUM = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int REVERSE       = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    input  logic [(2**LOG_INPUT_NUM)*DATA_WIDTH-1:0]  in_data,
    output logic                                      in_ready,
    output logic [DATA_WIDTH-1:0]                     out_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [LOG_INPUT_NUM-1:0]                  out_index,
    output logic                                      out_last,
    output logic                                      overflow,
    input  logic                                      ovf_clear
);

    localparam int N = 2**LOG_INPUT_NUM;

    // First and last word positions depend on the emission direction.
    localparam logic [LOG_INPUT_NUM-1:0] FIRST_IDX = {LOG_INPUT_NUM{REVERSE != 0}};
    localparam logic [LOG_INPUT_NUM-1:0] LAST_IDX  = {LOG_INPUT_NUM{REVERSE == 0}};

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                             state_q, state_d;
    logic [N-1:0][DATA_WIDTH-1:0]       hold_q, hold_d;
    logic [N-1:0][DATA_WIDTH-1:0]       in_words;
    logic [LOG_INPUT_NUM-1:0]           idx_q, idx_d, idx_step;
    logic [DATA_WIDTH-1:0]              data_q, data_d;
    logic                               last_q, last_d;
    logic                               ovf_q, ovf_d;
    logic                               xfer;
    logic                               capture;
    logic                               drop;

    assign in_words  = in_data;
    assign out_valid = (state_q == STREAM);
    assign out_data  = data_q;
    assign out_index = idx_q;
    assign out_last  = last_q;
    assign overflow  = ovf_q;

    // A new vector may land in the same cycle the final word leaves, so the
    // stream continues back-to-back without an idle bubble.
    assign xfer     = out_valid && out_ready;
    assign in_ready = (state_q == IDLE) || (xfer && last_q);
    assign capture  = in_valid && in_ready;
    assign drop     = in_valid && !in_ready;

    assign idx_step = (REVERSE != 0) ? (idx_q - LOG_INPUT_NUM'(1))
                                     : (idx_q + LOG_INPUT_NUM'(1));

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        ovf_d   = ovf_q;

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end

        if (capture) begin
            state_d = STREAM;
            hold_d  = in_words;
            idx_d   = FIRST_IDX;
            data_d  = in_words[FIRST_IDX];
            last_d  = 1'b0;
        end else if (xfer && last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
        end else if (xfer) begin
            idx_d  = idx_step;
            data_d = hold_q[idx_step];
            last_d = (idx_step == LAST_IDX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sort_result_serializer.sv
// Bench for sort_result_serializer: drives a forward and a reversed instance with
// identical stimulus and compares both against a queue-based model of the emitted words.
module tb_sort_result_serializer;

    localparam int LOGN = 4;
    localparam int N    = 16;
    localparam int W    = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           inValid;
    logic [N*W-1:0] inData;
    logic           outReady;
    logic           ovfClear;

    logic            inReady0, outValid0, outLast0, overflow0;
    logic [W-1:0]    outData0;
    logic [LOGN-1:0] outIndex0;
    logic            inReady1, outValid1, outLast1, overflow1;
    logic [W-1:0]    outData1;
    logic [LOGN-1:0] outIndex1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_result_serializer #(.LOG_INPUT_NUM(LOGN), .DATA_WIDTH(W), .REVERSE(0)) dutFwd (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData), .in_ready(inReady0),
        .out_data(outData0), .out_valid(outValid0), .out_ready(outReady),
        .out_index(outIndex0), .out_last(outLast0), .overflow(overflow0), .ovf_clear(ovfClear)
    );

    sort_result_serializer #(.LOG_INPUT_NUM(LOGN), .DATA_WIDTH(W), .REVERSE(1)) dutRev (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData), .in_ready(inReady1),
        .out_data(outData1), .out_valid(outValid1), .out_ready(outReady),
        .out_index(outIndex1), .out_last(outLast1), .overflow(overflow1), .ovf_clear(ovfClear)
    );

    // Model: queue of words still to be emitted; pos is the emission order within a vector.
    typedef struct {
        logic [N*W-1:0] vec;
        int             pos;
    } entry_t;

    entry_t modelQ[$];
    logic   modelOvf = 1'b0;

    typedef struct {
        logic inV;
        logic oR;
        logic clr;
        logic expValid;
        int   expIdx;
        logic expLast;
        logic expInReady;
        logic expOvf;
    } tvec_t;

    tvec_t vecTable[8];

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] buildVec(input int base);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(base + i);
        return v;
    endfunction

    function automatic logic [N*W-1:0] randomVec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = $urandom();
        return v;
    endfunction

    task automatic updateModel();
        logic   expInReady;
        entry_t e;
        expInReady = (modelQ.size() == 0) || (outReady && modelQ.size() == 1);
        if (modelQ.size() > 0 && outReady) void'(modelQ.pop_front());
        if (inValid && expInReady) begin
            for (int p = 0; p < N; p++) begin
                e.vec = inData;
                e.pos = p;
                modelQ.push_back(e);
            end
        end
        if (inValid && !expInReady) modelOvf = 1'b1;
        else if (ovfClear) modelOvf = 1'b0;
    endtask

    task automatic checkOne(input int r, input logic v, input logic [W-1:0] d,
                            input logic [LOGN-1:0] ix, input logic lst,
                            input logic ir, input logic ovf);
        logic           expValid;
        logic           expIr;
        int             ei;
        logic [N*W-1:0] tv;
        expValid = (modelQ.size() > 0);
        expIr    = (modelQ.size() == 0) || (outReady && modelQ.size() == 1);
        compare($sformatf("dut%0d out_valid", r), 64'(v), 64'(expValid));
        compare($sformatf("dut%0d in_ready", r), 64'(ir), 64'(expIr));
        compare($sformatf("dut%0d overflow", r), 64'(ovf), 64'(modelOvf));
        if (expValid) begin
            tv = modelQ[0].vec;
            ei = (r != 0) ? (N - 1 - modelQ[0].pos) : modelQ[0].pos;
            compare($sformatf("dut%0d out_data", r), 64'(d), 64'(tv[ei*W +: W]));
            compare($sformatf("dut%0d out_index", r), 64'(ix), 64'(ei));
            compare($sformatf("dut%0d out_last", r), 64'(lst), 64'(modelQ[0].pos == N - 1));
        end
    endtask

    task automatic checkOutput();
        checkOne(0, outValid0, outData0, outIndex0, outLast0, inReady0, overflow0);
        checkOne(1, outValid1, outData1, outIndex1, outLast1, inReady1, overflow1);
    endtask

    task automatic applyStimulus(input logic v, input logic [N*W-1:0] d,
                                 input logic oR, input logic clr);
        inValid  = v;
        inData   = d;
        outReady = oR;
        ovfClear = clr;
    endtask

    // Called at a falling edge with inputs driven; returns at the next falling edge.
    task automatic stepCycle();
        #1;
        checkOutput();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    task automatic doCycle(input logic v, input logic [N*W-1:0] d,
                           input logic oR, input logic clr);
        applyStimulus(v, d, oR, clr);
        stepCycle();
    endtask

    initial begin
        logic [N*W-1:0] vecA;
        logic [N*W-1:0] vecB;
        logic [N*W-1:0] vecT;

        vecTable[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecTable[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecTable[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecTable[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        vecTable[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0};
        vecTable[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b1};
        vecTable[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1};
        vecTable[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0};

        vecA = buildVec(100);
        vecB = buildVec(200);
        vecT = buildVec(300);

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        #1;
        compare("reset out_valid", 64'(outValid0), 64'(0));
        compare("reset out_last", 64'(outLast0), 64'(0));
        compare("reset out_index", 64'(outIndex0), 64'(0));
        compare("reset out_data", 64'(outData0), 64'(0));
        compare("reset overflow", 64'(overflow0), 64'(0));
        compare("reset rev out_valid", 64'(outValid1), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare("post-reset in_ready", 64'(inReady0), 64'(1));
        compare("post-reset rev in_ready", 64'(inReady1), 64'(1));

        $display("[TB] table-driven stall/drop/clear sequence");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecTable[i].inV, vecT, vecTable[i].oR, vecTable[i].clr);
            #1;
            compare($sformatf("table[%0d] out_valid", i), 64'(outValid0), 64'(vecTable[i].expValid));
            compare($sformatf("table[%0d] in_ready", i), 64'(inReady0), 64'(vecTable[i].expInReady));
            compare($sformatf("table[%0d] overflow", i), 64'(overflow0), 64'(vecTable[i].expOvf));
            if (vecTable[i].expValid) begin
                compare($sformatf("table[%0d] out_index", i), 64'(outIndex0), 64'(vecTable[i].expIdx));
                compare($sformatf("table[%0d] out_data", i), 64'(outData0), 64'(300 + vecTable[i].expIdx));
                compare($sformatf("table[%0d] out_last", i), 64'(outLast0), 64'(vecTable[i].expLast));
            end
            stepCycle();
        end
        for (int k = 0; k < 13; k++) doCycle(1'b0, '0, 1'b1, 1'b1);

        $display("[TB] single vector then back-to-back vector");
        doCycle(1'b1, vecA, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            if (k == 0) begin
                #1;
                compare("first word fwd", 64'(outData0), 64'(100));
                compare("first word rev", 64'(outData1), 64'(115));
                compare("first index rev", 64'(outIndex1), 64'(15));
            end
            stepCycle();
        end
        applyStimulus(1'b1, vecB, 1'b1, 1'b0);
        #1;
        compare("b2b in_ready", 64'(inReady0), 64'(1));
        compare("b2b last word", 64'(outData0), 64'(115));
        compare("b2b last flag", 64'(outLast0), 64'(1));
        compare("rev last word", 64'(outData1), 64'(100));
        stepCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        #1;
        compare("b2b next word", 64'(outData0), 64'(200));
        compare("b2b no bubble", 64'(outValid0), 64'(1));
        stepCycle();
        for (int k = 0; k < 17; k++) doCycle(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] backpressure pattern");
        doCycle(1'b1, vecA, 1'b1, 1'b0);
        for (int k = 0; k < 50; k++) doCycle(1'b0, '0, (k % 3) == 0, 1'b0);

        $display("[TB] reset mid-stream");
        doCycle(1'b1, vecB, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) doCycle(k == 3, vecA, 1'b1, 1'b0);
        #1;
        compare("pre-reset index", 64'(outIndex0), 64'(7));
        compare("pre-reset overflow", 64'(overflow0), 64'(1));
        #1;
        rst = 1'b1;
        #1;
        compare("async reset out_valid", 64'(outValid0), 64'(0));
        compare("async reset overflow", 64'(overflow0), 64'(0));
        compare("async reset rev out_valid", 64'(outValid1), 64'(0));
        compare("async reset rev overflow", 64'(overflow1), 64'(0));
        modelQ.delete();
        modelOvf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare("release in_ready", 64'(inReady0), 64'(1));
        doCycle(1'b1, vecT, 1'b1, 1'b0);
        for (int k = 0; k < 18; k++) doCycle(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 800; k++) begin
            doCycle($urandom_range(0, 11) == 0, randomVec(),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        for (int k = 0; k < 20; k++) doCycle(1'b0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_result_serializer.md
# sort_result_serializer

Output-side companion to the brick sorting network. It captures one sorted parallel vector when the sorter asserts its output-valid. It then streams the vector out one word per transfer over a valid/ready interface, so downstream logic with a single-word datapath can consume sorter results. The sorter has no backpressure, so any vector that arrives while the block is busy is dropped and flagged.

## Interface
- LOG_INPUT_NUM, 4, log2 of words per vector; N = 2**LOG_INPUT_NUM (N ≥ 2)
- DATA_WIDTH, 32, bits per word
- REVERSE, 0, 0: emit word index 0 first; 1: emit index N-1 first

- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  sorted vector present on in_data (driven from sorter y_valid)
- in_data  input  N*DATA_WIDTH  sorted vector; word i = in_data[i*DATA_WIDTH +: DATA_WIDTH]
- in_ready  output  1  a vector presented this cycle is captured (informational; the sorter ignores it)
- out_data  output  DATA_WIDTH  current word
- out_valid  output  1  out_data/out_index/out_last are valid
- out_ready  input  1  downstream accepts the word this cycle
- out_index  output  LOG_INPUT_NUM  index (within the vector) of the current word
- out_last  output  1  current word is the final word of the vector
- overflow  output  1  sticky: at least one vector was dropped
- ovf_clear  input  1  synchronous clear of overflow

## Operation
- Two states, IDLE and STREAM, plus a N*DATA_WIDTH holding register, an index counter and the overflow flag.
- Transfer: out_valid && out_ready in the same cycle.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational from out_ready.
- Capture: in_valid && in_ready loads the holding register, sets the index (0 if REVERSE=0, N-1 if REVERSE=1) and moves to STREAM.
- IDLE: out_valid=0. No capture leaves the block in IDLE.
- STREAM:
  - out_valid=1; out_data = held word[index]; out_index = index.
  - out_last = (index==N-1) for REVERSE=0, (index==0) for REVERSE=1.
  - A non-last transfer steps the index by ±1.
  - A last transfer goes to IDLE, unless a capture happens in the same cycle. In that case the block stays in STREAM with the new vector and the index reloaded (back-to-back, no bubble).
- Holding register and outputs are stable while out_valid && !out_ready.
- Drop: in_valid && !in_ready. The vector is discarded, the stream in progress is unaffected, and overflow is set on the next edge.
- ovf_clear clears overflow on the next edge. If a drop happens in the same cycle as ovf_clear, the set wins and overflow stays 1.
- out_data in IDLE holds its last value. Verification treats it as don't-care while out_valid=0.

## Timing
- Reset (asynchronous) gives:
  - state IDLE; out_valid=0, out_last=0, out_index=0, out_data=0, overflow=0.
  - holding register 0.
  - in_ready=1 immediately after reset deassertion.
- Reset mid-stream aborts the vector. No further words are emitted and nothing is flagged.
- Latency:
  - Capture at edge k gives the first word with out_valid=1 in cycle k+1.
  - With out_ready held high, a vector occupies exactly N consecutive cycles.
- Throughput: one vector per N cycles sustained when out_ready=1. The sorter's y_valid must be spaced at least N cycles apart to avoid drops.
- All outputs except in_ready are registered.

## Test plan
- Single vector: N=16, W=32, word i = 100+i, out_ready=1.
  - Words 100..115 appear on 16 consecutive cycles starting one cycle after capture.
  - out_index runs 0..15; out_last is 1 only with word 115.
  - Back to IDLE after the last word; overflow=0.
- Backpressure: same vector, out_ready toggled 1,0,0,1,...
  - Every word is emitted exactly once, in order.
  - out_data, out_index and out_last are held constant through every stalled cycle.
- Back-to-back: second vector (200+i) presented in the cycle of word 115's transfer.
  - in_ready=1 in that cycle.
  - Word 200 follows 115 with no idle cycle; 32 words total; overflow=0.
- Overflow: second vector presented when index=5 of the first.
  - That vector is dropped and the first completes intact; overflow=1 from the next cycle.
  - ovf_clear pulse returns overflow to 0.
  - Repeat with a drop and ovf_clear in the same cycle: overflow stays 1.
- Reset mid-stream: assert rst asynchronously during word 7.
  - out_valid=0 and overflow=0 immediately.
  - After release, in_ready=1 and a new vector streams correctly from index 0.
- REVERSE=1: vector 100+i.
  - Output order 115 down to 100; out_index 15..0; out_last only with word 100.
